// File: rtl/stepper_pkg.sv
// Shared types and coil tables for the stepper sequencer.
package stepper_pkg;

  localparam int DEF_PERIOD_W = 24;
  localparam int DEF_STEPS_W  = 16;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  // Entry 0 is the rightmost element: 0011, 1001, 1100, 0110.
  localparam logic [3:0][3:0] FULL_TBL = {4'b0110, 4'b1100, 4'b1001, 4'b0011};

  // Even entries coincide with FULL_TBL so full-step moves can share the table.
  localparam logic [7:0][3:0] HALF_TBL = {4'b0010, 4'b0110, 4'b0100, 4'b1100,
                                          4'b1000, 4'b1001, 4'b0001, 4'b0011};

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module step_timer #(
  parameter int W = 8
)(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                    r_cnt <= '0;
    else if (i_load)               r_cnt <= i_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Command-driven full-step sequencer for the 4-coil unipolar stepper.
// Optional half-step support is enabled by defining STEPPER_HALF_STEP_EN.
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int PERIOD_W    = DEF_PERIOD_W,
  parameter int STEPS_W     = DEF_STEPS_W,
  parameter int HOLD_CYCLES = 1048576
)(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_DIR,
  input  logic [STEPS_W-1:0]  CMD_STEPS,
  input  logic [PERIOD_W-1:0] PERIOD,
  input  logic                ABORT,
`ifdef STEPPER_HALF_STEP_EN
  input  logic                HALF_MODE,
`endif
  output logic [3:0]          PHASE,
  output logic                BUSY,
  output logic                DONE,
  output logic                ABORTED,
  output logic [STEPS_W-1:0]  POS
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
`ifdef STEPPER_HALF_STEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt, w_stride;
  logic [STEPS_W-1:0]  r_rem, r_pos;
  logic [PERIOD_W-1:0] r_reload, w_per_m1, w_per_val;
  logic                r_dir;
  logic [3:0]          r_phase, w_phase_nxt, w_coil;
  logic                r_done, r_aborted, w_done_nxt, w_abrt_nxt;
  logic                w_accept, w_zero, w_step, w_abort, w_last;
  logic                w_run, w_per_load, w_per_tc, w_hold_load, w_hold_en, w_hold_tc;

  assign w_run      = (r_state == RUN);
  assign w_accept   = CMD_VALID && !w_run;
  assign w_zero     = (CMD_STEPS == '0);
  assign w_per_m1   = (PERIOD == '0) ? '0 : PERIOD - 1'b1;
  // ABORT on the step-due cycle wins, so the pending step is dropped.
  assign w_abort    = w_run && ABORT;
  assign w_step     = w_run && w_per_tc && !ABORT;
  assign w_last     = w_step && (r_rem == STEPS_W'(1));
  assign w_per_load = (w_accept && !w_zero) || w_step;
  assign w_per_val  = w_accept ? w_per_m1 : r_reload;
  assign w_hold_load = w_abort || w_last || (w_accept && w_zero && r_state == HOLD);
  assign w_hold_en  = (r_state == HOLD);

`ifdef STEPPER_HALF_STEP_EN
  logic r_half;
  // Full-step moves starting on an odd entry take one half step to realign.
  assign w_stride = (r_half || r_idx[0]) ? IDX_W'(1) : IDX_W'(2);
  assign w_coil   = HALF_TBL[w_idx_nxt];
`else
  assign w_stride = IDX_W'(1);
  assign w_coil   = FULL_TBL[w_idx_nxt];
`endif

  assign w_idx_nxt = !w_step ? r_idx : (r_dir ? r_idx + w_stride : r_idx - w_stride);

  step_timer #(.W(PERIOD_W)) u_per_tmr (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_load (w_per_load),
    .i_val  (w_per_val),
    .i_en   (w_run),
    .o_tc   (w_per_tc)
  );

  step_timer #(.W(HOLD_W)) u_hold_tmr (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_load (w_hold_load),
    .i_val  (HOLD_W'(HOLD_CYCLES - 1)),
    .i_en   (w_hold_en),
    .o_tc   (w_hold_tc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && !w_zero) w_state_nxt = RUN;
      RUN:     if (w_abort || w_last)   w_state_nxt = HOLD;
      HOLD: begin
        if (w_accept)       w_state_nxt = w_zero ? HOLD : RUN;
        else if (w_hold_tc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_phase_nxt = (w_state_nxt == IDLE) ? 4'b0000 : w_coil;
    w_done_nxt  = (w_accept && w_zero) || w_abort || w_last;
    w_abrt_nxt  = w_abort;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx     <= '0;
      r_pos     <= '0;
      r_rem     <= '0;
      r_reload  <= '0;
      r_dir     <= 1'b0;
      r_phase   <= 4'b0000;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
`ifdef STEPPER_HALF_STEP_EN
      r_half    <= 1'b0;
`endif
    end else begin
      r_idx     <= w_idx_nxt;
      r_phase   <= w_phase_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_abrt_nxt;
      if (w_accept) begin
        r_dir    <= CMD_DIR;
        r_rem    <= CMD_STEPS;
        r_reload <= w_per_m1;
`ifdef STEPPER_HALF_STEP_EN
        r_half   <= HALF_MODE;
`endif
      end else if (w_step) begin
        r_rem <= r_rem - 1'b1;
      end
      if (w_step) r_pos <= r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
    end
  end

  assign PHASE     = r_phase;
  assign CMD_READY = !w_run;
  assign BUSY      = w_run;
  assign DONE      = r_done;
  assign ABORTED   = r_aborted;
  assign POS       = r_pos;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed bench for stepper_seq_ctrl with a short hold time.
module tb_stepper_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, CMD_VALID, CMD_READY, CMD_DIR, ABORT;
  logic [15:0] CMD_STEPS, POS;
  logic [23:0] PERIOD;
  logic [3:0]  PHASE;
  logic        BUSY, DONE, ABORTED;
`ifdef STEPPER_HALF_STEP_EN
  logic        HALF_MODE = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] exp_fw   [4] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};
  logic [3:0] exp_rv   [3] = '{4'b0110, 4'b1100, 4'b1001};
  logic [3:0] exp_hph  [5] = '{4'b0011, 4'b0011, 4'b0110, 4'b0110, 4'b1100};
  logic       exp_hrdy [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] prev;

  always #5 CLK = ~CLK;

  stepper_seq_ctrl #(.PERIOD_W(24), .STEPS_W(16), .HOLD_CYCLES(20)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_DIR   (CMD_DIR),
    .CMD_STEPS (CMD_STEPS),
    .PERIOD    (PERIOD),
    .ABORT     (ABORT),
`ifdef STEPPER_HALF_STEP_EN
    .HALF_MODE (HALF_MODE),
`endif
    .PHASE     (PHASE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ABORTED   (ABORTED),
    .POS       (POS)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    CMD_VALID = 1'b0; ABORT = 1'b0; RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic send(input logic dir, input logic [15:0] steps, input logic [23:0] per);
    CMD_VALID = 1'b1; CMD_DIR = dir; CMD_STEPS = steps; PERIOD = per;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int i = 0;
    while (!DONE && i < max) begin tick(); i++; end
    chk("done_timeout", DONE, 1);
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (PHASE != 4'b0000 && i < max) begin tick(); i++; end
    chk("idle_timeout", PHASE, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    CMD_VALID = 0; CMD_DIR = 0; CMD_STEPS = 0; PERIOD = 0; ABORT = 0; RST_N = 0;
    do_reset();
    chk("rst_phase", PHASE, 0);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_aborted", ABORTED, 0);
    chk("rst_pos", POS, 0);

    // Forward 4 steps, period 10.
    send(1'b1, 16'd4, 24'd10);
    chk("fw_phase0", PHASE, 4'b0011);
    chk("fw_busy", BUSY, 1);
    chk("fw_ready", CMD_READY, 0);
    prev = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      repeat (9) tick();
      chk("fw_pre", PHASE, prev);
      tick();
      chk("fw_step", PHASE, exp_fw[k]);
      chk("fw_done", DONE, (k == 3));
      prev = exp_fw[k];
    end
    chk("fw_aborted", ABORTED, 0);
    chk("fw_pos", POS, 16'd4);
    tick();
    chk("fw_done_pulse", DONE, 0);
    repeat (18) tick();
    chk("hold_phase", PHASE, 4'b0011);
    chk("hold_ready", CMD_READY, 1);
    tick();
    chk("release_phase", PHASE, 4'b0000);

    // Reverse 3 steps, period 1, from index 0.
    do_reset();
    send(1'b0, 16'd3, 24'd1);
    chk("rv_phase0", PHASE, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rv_step", PHASE, exp_rv[k]);
    end
    chk("rv_done", DONE, 1);
    chk("rv_aborted", ABORTED, 0);
    chk("rv_pos", POS, 16'hFFFD);

    // Abort on the 8th step-due cycle.
    do_reset();
    send(1'b1, 16'd100, 24'd5);
    repeat (35) tick();
    chk("ab_pos7", POS, 16'd7);
    chk("ab_ready", CMD_READY, 0);
    repeat (4) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_done", DONE, 1);
    chk("ab_aborted", ABORTED, 1);
    chk("ab_pos", POS, 16'd7);
    chk("ab_phase", PHASE, 4'b0110);
    chk("ab_busy", BUSY, 0);
    tick();
    chk("ab_done_pulse", DONE, 0);
    chk("ab_phase_frz", PHASE, 4'b0110);
    wait_idle(100);

    // Zero-step command in IDLE.
    send(1'b1, 16'd0, 24'd3);
    chk("z_done", DONE, 1);
    chk("z_aborted", ABORTED, 0);
    chk("z_pos", POS, 16'd7);
    chk("z_phase", PHASE, 4'b0000);
    chk("z_ready", CMD_READY, 1);

    // One step to land in HOLD, then a second command from HOLD.
    send(1'b1, 16'd1, 24'd2);
    chk("h1_phase0", PHASE, 4'b0110);
    repeat (2) tick();
    chk("h1_done", DONE, 1);
    chk("h1_phase", PHASE, 4'b0011);
    repeat (3) tick();
    chk("h1_hold", PHASE, 4'b0011);
    send(1'b0, 16'd2, 24'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk("h2_phase", PHASE, exp_hph[k]);
      chk("h2_ready", CMD_READY, exp_hrdy[k]);
    end
    chk("h2_done", DONE, 1);
    chk("h2_pos", POS, 16'd6);

    // Position wrap past the signed maximum.
    do_reset();
    send(1'b1, 16'h7FFF, 24'd1);
    wait_done(40000);
    chk("wr_pos7fff", POS, 16'h7FFF);
    send(1'b1, 16'd1, 24'd1);
    tick();
    chk("wr_done", DONE, 1);
    chk("wr_pos8000", POS, 16'h8000);

    // Reset mid-move.
    send(1'b1, 16'd10, 24'd3);
    repeat (4) tick();
    chk("mr_pos", POS, 16'h8001);
    #2 RST_N = 1'b0;
    #1;
    chk("mr_phase", PHASE, 0);
    chk("mr_pos0", POS, 0);
    chk("mr_ready", CMD_READY, 1);
    chk("mr_busy", BUSY, 0);
    chk("mr_done", DONE, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    chk("mr_done_after", DONE, 0);
    chk("mr_phase_after", PHASE, 0);

`ifdef STEPPER_HALF_STEP_EN
    do_reset();
    HALF_MODE = 1'b1;
    send(1'b1, 16'd3, 24'd1);
    HALF_MODE = 1'b0;
    tick(); chk("hs_p1", PHASE, 4'b0001);
    tick(); chk("hs_p2", PHASE, 4'b1001);
    tick(); chk("hs_p3", PHASE, 4'b1000);
    chk("hs_done", DONE, 1);
    send(1'b1, 16'd1, 24'd1);
    tick();
    chk("hs_realign", PHASE, 4'b1100);
    chk("hs_pos", POS, 16'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
